// File: rtl/iq_multi.sv
// iq_multi: multi-slot in-order instruction queue between fetch and rename, flushed on mispredict.
// Define IQ_BYPASS_EN to let an empty queue forward fetched slots straight to dispatch.
module iq_multi #(
    parameter int DEPTH = 8,
    parameter int IN_W  = 2,
    parameter int OUT_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [IN_W-1:0]        in_valid,
    input  logic [IN_W*32-1:0]     in_inst,
    input  logic [IN_W*32-1:0]     in_pc4,
    input  logic [IN_W-1:0]        in_branch_valid,
    input  logic [IN_W*32-1:0]     in_btb_pc_predict,
    input  logic [IN_W-1:0]        in_direct_predict,
    output logic                   iq_full,
    input  logic                   stall_backend,
    input  logic                   mispredict,
    output logic [OUT_W-1:0]       out_valid,
    output logic [OUT_W*32-1:0]    out_inst,
    output logic [OUT_W*32-1:0]    out_pc4,
    output logic [OUT_W-1:0]       out_branch_valid,
    output logic [OUT_W*32-1:0]    out_btb_pc_predict,
    output logic [OUT_W-1:0]       out_direct_predict,
    output logic                   iq_empty,
    output logic [$clog2(DEPTH):0] iq_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   pc4_q  [DEPTH];
    logic [31:0]   btb_q  [DEPTH];
    logic          bv_q   [DEPTH];
    logic          dp_q   [DEPTH];
    logic [AW-1:0] head, tail;
    logic [CW-1:0] count, n, p, b, w;
    logic          push, run;
    logic [AW-1:0] widx [IN_W];
    logic [IN_W-1:0] wen;

    assign iq_full  = count > CW'(DEPTH - IN_W);
    assign iq_empty = count == '0;
    assign iq_count = count;
    assign push     = !iq_full && !mispredict;
    assign p        = (stall_backend || mispredict) ? '0 : (count < CW'(OUT_W) ? count : CW'(OUT_W));
    assign w        = push ? n - b : '0;

    // n is the length of the contiguous valid prefix; slots after the first gap are dropped
    always_comb begin
        n   = '0;
        run = 1'b1;
        for (int k = 0; k < IN_W; k++) begin
            run = run & in_valid[k];
            n   = n + CW'(run);
        end
    end

`ifdef IQ_BYPASS_EN
    logic byp;
    assign byp = iq_empty && !mispredict;
    assign b   = (byp && !stall_backend) ? (n < CW'(OUT_W) ? n : CW'(OUT_W)) : '0;
`else
    assign b = '0;
`endif

    // slots below b were consumed by the bypass; the rest pack down onto tail
    always_comb begin
        for (int k = 0; k < IN_W; k++) begin
            widx[k] = tail + AW'(k) - AW'(b);
            wen[k]  = push && CW'(k) >= b && CW'(k) < n;
        end
    end

    for (genvar k = 0; k < OUT_W; k++) begin : g_out
        logic [AW-1:0] idx;
        assign idx = head + AW'(k);
`ifdef IQ_BYPASS_EN
        localparam int S = k < IN_W ? k : 0;
        logic byp_k;
        assign byp_k                         = byp && (k < IN_W) && CW'(k) < n;
        assign out_valid[k]                  = !mispredict && (byp ? byp_k : count > CW'(k));
        assign out_inst[32*k+:32]            = byp_k ? in_inst[32*S+:32] : inst_q[idx];
        assign out_pc4[32*k+:32]             = byp_k ? in_pc4[32*S+:32] : pc4_q[idx];
        assign out_btb_pc_predict[32*k+:32]  = byp_k ? in_btb_pc_predict[32*S+:32] : btb_q[idx];
        assign out_branch_valid[k]           = byp_k ? in_branch_valid[S] : bv_q[idx];
        assign out_direct_predict[k]         = byp_k ? in_direct_predict[S] : dp_q[idx];
`else
        assign out_valid[k]                  = !mispredict && count > CW'(k);
        assign out_inst[32*k+:32]            = inst_q[idx];
        assign out_pc4[32*k+:32]             = pc4_q[idx];
        assign out_btb_pc_predict[32*k+:32]  = btb_q[idx];
        assign out_branch_valid[k]           = bv_q[idx];
        assign out_direct_predict[k]         = dp_q[idx];
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc4_q[i]  <= '0;
                btb_q[i]  <= '0;
                bv_q[i]   <= 1'b0;
                dp_q[i]   <= 1'b0;
            end
        end else if (mispredict) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int k = 0; k < IN_W; k++) begin
                if (wen[k]) begin
                    inst_q[widx[k]] <= in_inst[32*k+:32];
                    pc4_q[widx[k]]  <= in_pc4[32*k+:32];
                    btb_q[widx[k]]  <= in_btb_pc_predict[32*k+:32];
                    bv_q[widx[k]]   <= in_branch_valid[k];
                    dp_q[widx[k]]   <= in_direct_predict[k];
                end
            end
            head  <= head + AW'(p);
            tail  <= tail + AW'(w);
            count <= count + w - p;
        end
    end

`ifndef SYNTHESIS
    assert property (@(posedge clk) disable iff (!rst) count <= CW'(DEPTH))
        else $error("iq_multi: count exceeds DEPTH");
`endif
endmodule

// File: tb/tb_iq_multi.sv
// tb_iq_multi: directed checks of iq_multi at DEPTH=8, IN_W=2, OUT_W=2.
module tb_iq_multi;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [63:0] in_inst, in_pc4, in_btb_pc_predict;
    logic [1:0]  in_branch_valid, in_direct_predict;
    logic        iq_full, stall_backend, mispredict, iq_empty;
    logic [1:0]  out_valid, out_branch_valid, out_direct_predict;
    logic [63:0] out_inst, out_pc4, out_btb_pc_predict;
    logic [3:0]  iq_count;
    int          errors = 0;
    int          checks = 0;

    iq_multi #(.DEPTH(8), .IN_W(2), .OUT_W(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_inst(in_inst), .in_pc4(in_pc4),
        .in_branch_valid(in_branch_valid), .in_btb_pc_predict(in_btb_pc_predict),
        .in_direct_predict(in_direct_predict), .iq_full(iq_full), .stall_backend(stall_backend),
        .mispredict(mispredict), .out_valid(out_valid), .out_inst(out_inst), .out_pc4(out_pc4),
        .out_branch_valid(out_branch_valid), .out_btb_pc_predict(out_btb_pc_predict),
        .out_direct_predict(out_direct_predict), .iq_empty(iq_empty), .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    // slot 0 carries pc a, slot 1 carries pc b; metadata derived from the pc
    task automatic drive(input logic [1:0] v, input logic [31:0] a, input logic [31:0] b);
        in_valid          = v;
        in_pc4            = {b, a};
        in_inst           = {mk(b), mk(a)};
        in_btb_pc_predict = {b + 32'h100, a + 32'h100};
        in_branch_valid   = {b[2], a[2]};
        in_direct_predict = {b[3], a[3]};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_pair(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ba = a + 32'h100;
        logic [31:0] bb = b + 32'h100;
        check({tag, "_valid"}, 64'(out_valid), 64'h3);
        check({tag, "_pc4"}, out_pc4, {b, a});
        check({tag, "_inst"}, out_inst, {mk(b), mk(a)});
        check({tag, "_btb"}, out_btb_pc_predict, {bb, ba});
        check({tag, "_bv"}, 64'(out_branch_valid), 64'({b[2], a[2]}));
        check({tag, "_dp"}, 64'(out_direct_predict), 64'({b[3], a[3]}));
    endtask

    initial begin
        rst = 1'b0;
        stall_backend = 1'b0;
        mispredict = 1'b0;
        drive(2'b00, 0, 0);
        #12;
        check("rst_valid", 64'(out_valid), 0);
        check("rst_empty", 64'(iq_empty), 1);
        check("rst_full", 64'(iq_full), 0);
        check("rst_count", 64'(iq_count), 0);
        check("rst_inst", out_inst, 0);
        rst = 1'b1;
        tick;
        // fill under stall, then offer a pair that must be dropped
        stall_backend = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 32'(8*i+4), 32'(8*i+8));
            tick;
            check("fill_count", 64'(iq_count), 64'(2*(i+1)));
        end
        check("fill_full", 64'(iq_full), 1);
        check("fill_valid", 64'(out_valid), 3);
        drive(2'b11, 32'h24, 32'h28);
        tick;
        check("drop_count", 64'(iq_count), 8);
        check("drop_head_pc4", out_pc4, {32'h8, 32'h4});
        stall_backend = 1'b0;
        drive(2'b00, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_pair("drain", 32'(8*i+4), 32'(8*i+8));
            tick;
        end
        check("drain_empty", 64'(iq_empty), 1);
        check("drain_valid", 64'(out_valid), 0);
        drive(2'b10, 32'h200, 32'h204);
        tick;
        check("gap_count", 64'(iq_count), 0);
        // steady push 2 / pop 2 wraps the pointers twice
        drive(2'b11, 32'h100, 32'h104);
        tick;
        for (int i = 1; i <= 10; i++) begin
            drive(2'b11, 32'(32'h100 + 8*i), 32'(32'h104 + 8*i));
            #1;
            check_pair("wrap", 32'(32'h100 + 8*(i-1)), 32'(32'h104 + 8*(i-1)));
            tick;
            check("wrap_count", 64'(iq_count), 2);
        end
        drive(2'b00, 0, 0);
        #1;
        check("wrap_last_pc4", out_pc4, {32'h154, 32'h150});
        tick;
        check("wrap_empty", 64'(iq_empty), 1);
        // mispredict with count=5 discards the same-cycle push
        stall_backend = 1'b1;
        drive(2'b11, 32'h400, 32'h404);
        tick;
        drive(2'b11, 32'h408, 32'h40C);
        tick;
        drive(2'b01, 32'h410, 0);
        tick;
        check("mp_pre_count", 64'(iq_count), 5);
        drive(2'b11, 32'h500, 32'h504);
        mispredict = 1'b1;
        #1;
        check("mp_comb_valid", 64'(out_valid), 0);
        tick;
        mispredict = 1'b0;
        drive(2'b00, 0, 0);
        #1;
        check("mp_count", 64'(iq_count), 0);
        check("mp_valid", 64'(out_valid), 0);
        check("mp_empty", 64'(iq_empty), 1);
        drive(2'b01, 32'h600, 0);
        tick;
        check("mp_after_pc4", 64'(out_pc4[31:0]), 64'h600);
        check("mp_after_count", 64'(iq_count), 1);
        mispredict = 1'b1;
        drive(2'b00, 0, 0);
        tick;
        mispredict = 1'b0;
        // single-instruction latency on an empty queue
        stall_backend = 1'b0;
        drive(2'b01, 32'h40, 0);
        in_inst = {32'h0, 32'h2008_0001};
        #1;
`ifdef IQ_BYPASS_EN
        check("lat_same_valid", 64'(out_valid), 1);
        check("lat_same_inst", 64'(out_inst[31:0]), 64'h2008_0001);
        tick;
        drive(2'b00, 0, 0);
        #1;
        check("lat_next_count", 64'(iq_count), 0);
`else
        check("lat_same_valid", 64'(out_valid), 0);
        tick;
        drive(2'b00, 0, 0);
        #1;
        check("lat_next_valid", 64'(out_valid), 1);
        check("lat_next_inst", 64'(out_inst[31:0]), 64'h2008_0001);
        check("lat_next_pc4", 64'(out_pc4[31:0]), 64'h40);
        check("lat_next_count", 64'(iq_count), 1);
`endif
        tick;
        check("lat_empty", 64'(iq_empty), 1);
        // asynchronous reset in the middle of a run with count=5
        stall_backend = 1'b1;
        drive(2'b11, 32'h700, 32'h704);
        tick;
        drive(2'b11, 32'h708, 32'h70C);
        tick;
        drive(2'b01, 32'h710, 0);
        tick;
        check("mid_pre_count", 64'(iq_count), 5);
        drive(2'b00, 0, 0);
        rst = 1'b0;
        #1;
        check("mid_valid", 64'(out_valid), 0);
        check("mid_empty", 64'(iq_empty), 1);
        check("mid_count", 64'(iq_count), 0);
        check("mid_full", 64'(iq_full), 0);
        #2;
        rst = 1'b1;
        tick;
        check("mid_post_count", 64'(iq_count), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
